dynamic_branch_predictor: RTL and testbench

- Fetch-stage predictor for the MIPS-I core: decodes the fetched instruction in the same cycle and produces taken/target.
- Replaces fixed backward-taken prediction with:
  - a parametrised table of 2-bit saturating counters (BHT) for conditional branches;
  - a return-address stack (RAS) for JR $31 targets.
- Trained by the execute stage. The RAS is repaired on pipeline flush from a checkpoint that travels with each instruction.

---
 rtl/bp_pkg.sv | 45 ++++
 rtl/return_address_stack.sv | 92 +++++++++
 rtl/dynamic_branch_predictor.sv | 150 +++++++++++++++
 tb/tb_dynamic_branch_predictor.sv | 377 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bp_pkg.sv
// Shared decode constants and counter helpers for the fetch-stage branch predictor.
// Latency: none (package only).
// Backpressure: none (package only).
package bp_pkg;

    localparam int REG_WIDTH = 32;

    // Primary opcodes (inst[31:26])
    localparam logic [5:0] OP_SPECIAL = 6'b000000;
    localparam logic [5:0] OP_REGIMM  = 6'b000001;
    localparam logic [5:0] OP_J       = 6'b000010;
    localparam logic [5:0] OP_JAL     = 6'b000011;
    localparam logic [5:0] OP_BEQ     = 6'b000100;
    localparam logic [5:0] OP_BNE     = 6'b000101;
    localparam logic [5:0] OP_BLEZ    = 6'b000110;
    localparam logic [5:0] OP_BGTZ    = 6'b000111;

    // SPECIAL function codes (inst[5:0])
    localparam logic [5:0] FN_JR   = 6'b001000;
    localparam logic [5:0] FN_JALR = 6'b001001;

    // REGIMM rt selectors (inst[20:16])
    localparam logic [4:0] RT_BLTZ   = 5'b00000;
    localparam logic [4:0] RT_BGEZ   = 5'b00001;
    localparam logic [4:0] RT_BLTZAL = 5'b10000;
    localparam logic [4:0] RT_BGEZAL = 5'b10001;

    // Link register used by the return convention
    localparam logic [4:0] REG_RA = 5'd31;

    typedef logic [1:0] ctr2_t;

    // Two-bit saturating counter step toward the resolved outcome.
    function automatic ctr2_t ctr_next(input ctr2_t c, input logic taken);
        ctr2_t n;
        n = c;
        if (taken && (c != 2'b11)) begin
            n = c + 2'd1;
        end else if (!taken && (c != 2'b00)) begin
            n = c - 2'd1;
        end
        return n;
    endfunction

endpackage

// File: rtl/return_address_stack.sv
// Circular return-address stack with checkpoint/restore for flush repair.
// Latency: top entry and checkpoint are combinational; push/pop/restore land at the clock edge.
// Backpressure: stall freezes state; flush restores {ptr,count} and discards same-cycle push/pop.
//
// Ports: clk/rst (sync, active-high); push_req/pop_req from decode (already fetch_valid-qualified);
// push_addr = return address to store; top_vld/top_addr = current prediction;
// ckpt = {ptr,count} after this instruction's own push/pop; flush/flush_ckpt = repair.
module return_address_stack
    import bp_pkg::*;
#(
    parameter  int RAS_DEPTH = 8,
    localparam int PW        = $clog2(RAS_DEPTH),
    localparam int CW        = $clog2(RAS_DEPTH + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 push_req,
    input  logic                 pop_req,
    input  logic                 stall,
    input  logic                 flush,
    input  logic [PW+CW-1:0]     flush_ckpt,
    input  logic [REG_WIDTH-1:0] push_addr,
    output logic                 top_vld,
    output logic [REG_WIDTH-1:0] top_addr,
    output logic [PW+CW-1:0]     ckpt
);

    localparam logic [CW-1:0] FULL = CW'(RAS_DEPTH);

    logic [PW-1:0]        ptr_q, ptr_d, ptr_adv;
    logic [CW-1:0]        cnt_q, cnt_d, cnt_adv;
    logic [REG_WIDTH-1:0] stack_q [RAS_DEPTH];
    logic [REG_WIDTH-1:0] stack_d [RAS_DEPTH];
    logic                 commit;

    // Kept apart from the update logic so the decode path reading the top
    // entry never loops back through push/pop requests.
    assign top_vld  = (cnt_q != '0);
    assign top_addr = top_vld ? stack_q[ptr_q - 1'b1] : '0;

    always_comb begin
        ptr_adv = ptr_q;
        cnt_adv = cnt_q;
        commit  = !stall && !flush;
        stack_d = stack_q;

        // Full stack: ptr keeps wrapping, so the oldest slot is overwritten
        // while count stays pinned at depth.
        if (push_req) begin
            ptr_adv = ptr_q + 1'b1;
            cnt_adv = (cnt_q == FULL) ? FULL : cnt_q + 1'b1;
        end else if (pop_req && (cnt_q != '0)) begin
            ptr_adv = ptr_q - 1'b1;
            cnt_adv = cnt_q - 1'b1;
        end

        // Checkpoint describes the instruction's effect regardless of stall,
        // because it travels with the instruction once it actually advances.
        ckpt = {ptr_adv, cnt_adv};

        if (flush) begin
            ptr_d = flush_ckpt[PW+CW-1:CW];
            cnt_d = flush_ckpt[CW-1:0];
        end else if (commit) begin
            ptr_d = ptr_adv;
            cnt_d = cnt_adv;
        end else begin
            ptr_d = ptr_q;
            cnt_d = cnt_q;
        end

        if (push_req && commit) begin
            stack_d[ptr_q] = push_addr;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= '0;
            cnt_q <= '0;
        end else begin
            ptr_q <= ptr_d;
            cnt_q <= cnt_d;
        end
    end

    // Entry contents carry no reset; a pop never clears them.
    always_ff @(posedge clk) begin
        stack_q <= stack_d;
    end

endmodule

// File: rtl/dynamic_branch_predictor.sv
// Fetch-stage predictor: same-cycle decode, 2-bit BHT for conditional branches, RAS for JR $31.
// Latency: prediction is combinational from pc/inst/state; BHT training and RAS updates land at the clock edge.
// Backpressure: stall holds RAS state; flush repairs RAS from the redirecting instruction's checkpoint.
//
// Ports: fetch_valid/stall/pc/inst in; branch_taken/is_branch/is_call/is_return/branch_address/ras_ckpt out;
// upd_valid/upd_pc/upd_taken train the BHT from execute; flush/flush_ckpt repair the RAS.
module dynamic_branch_predictor
    import bp_pkg::*;
#(
    parameter  int    BHT_ENTRIES  = 256,
    parameter  int    RAS_DEPTH    = 8,
    parameter  ctr2_t COUNTER_INIT = 2'b01,
    localparam int    PW           = $clog2(RAS_DEPTH),
    localparam int    CW           = $clog2(RAS_DEPTH + 1),
    localparam int    IW           = $clog2(BHT_ENTRIES)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 fetch_valid,
    input  logic                 stall,
    input  logic [REG_WIDTH-1:0] pc,
    input  logic [REG_WIDTH-1:0] inst,
    output logic                 branch_taken,
    output logic                 is_branch,
    output logic                 is_call,
    output logic                 is_return,
    output logic [REG_WIDTH-1:0] branch_address,
    output logic [PW+CW-1:0]     ras_ckpt,
    input  logic                 upd_valid,
    input  logic [REG_WIDTH-1:0] upd_pc,
    input  logic                 upd_taken,
    input  logic                 flush,
    input  logic [PW+CW-1:0]     flush_ckpt
);

    ctr2_t                bht_q [BHT_ENTRIES];
    ctr2_t                bht_d [BHT_ENTRIES];
    logic [IW-1:0]        idx, upd_idx;
    logic [REG_WIDTH-1:0] pc4, pc8, bt, jt;
    logic                 cond_taken;
    logic                 ras_top_vld;
    logic [REG_WIDTH-1:0] ras_top_addr;
    logic                 unused_bits;

    assign unused_bits = ^{upd_pc[REG_WIDTH-1:IW+2], upd_pc[1:0]};

    assign idx     = pc[IW+1:2];
    assign upd_idx = upd_pc[IW+1:2];
    assign pc4     = pc + 32'd4;
    assign pc8     = pc + 32'd8;
    assign bt      = pc4 + {{14{inst[15]}}, inst[15:0], 2'b00};
    assign jt      = {pc4[31:28], inst[25:0], 2'b00};

    // Read uses the registered table, so a same-cycle update to this index
    // is not visible until the next cycle.
    assign cond_taken = bht_q[idx][1];

    always_comb begin
        bht_d = bht_q;
        if (upd_valid) begin
            bht_d[upd_idx] = ctr_next(bht_q[upd_idx], upd_taken);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < BHT_ENTRIES; i++) begin
                bht_q[i] <= COUNTER_INIT;
            end
        end else begin
            bht_q <= bht_d;
        end
    end

    always_comb begin
        branch_taken   = 1'b0;
        is_branch      = 1'b0;
        is_call        = 1'b0;
        is_return      = 1'b0;
        branch_address = '0;
        if (fetch_valid) begin
            case (inst[31:26])
                OP_J: begin
                    is_branch      = 1'b1;
                    branch_taken   = 1'b1;
                    branch_address = jt;
                end
                OP_JAL: begin
                    is_branch      = 1'b1;
                    is_call        = 1'b1;
                    branch_taken   = 1'b1;
                    branch_address = jt;
                end
                OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ: begin
                    is_branch      = 1'b1;
                    branch_taken   = cond_taken;
                    branch_address = bt;
                end
                OP_REGIMM: begin
                    case (inst[20:16])
                        RT_BLTZ, RT_BGEZ: begin
                            is_branch      = 1'b1;
                            branch_taken   = cond_taken;
                            branch_address = bt;
                        end
                        // Linking forms only push when we expect to follow the link.
                        RT_BLTZAL, RT_BGEZAL: begin
                            is_branch      = 1'b1;
                            is_call        = cond_taken;
                            branch_taken   = cond_taken;
                            branch_address = bt;
                        end
                        default: ;
                    endcase
                end
                OP_SPECIAL: begin
                    if (inst[5:0] == FN_JR) begin
                        is_branch = 1'b1;
                        if (inst[25:21] == REG_RA) begin
                            is_return      = 1'b1;
                            branch_taken   = ras_top_vld;
                            branch_address = ras_top_addr;
                        end
                    end else if (inst[5:0] == FN_JALR) begin
                        is_branch = 1'b1;
                        is_call   = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    return_address_stack #(
        .RAS_DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk        (clk),
        .rst        (rst),
        .push_req   (is_call),
        .pop_req    (is_return),
        .stall      (stall),
        .flush      (flush),
        .flush_ckpt (flush_ckpt),
        .push_addr  (pc8),
        .top_vld    (ras_top_vld),
        .top_addr   (ras_top_addr),
        .ckpt       (ras_ckpt)
    );

endmodule

// File: tb/tb_dynamic_branch_predictor.sv
module tb_dynamic_branch_predictor;

    localparam int BHT = 256;
    localparam int D   = 8;
    localparam int PW  = $clog2(D);
    localparam int CW  = $clog2(D + 1);

    logic          clk = 1'b0;
    logic          rst, fetch_valid, stall, upd_valid, upd_taken, flush;
    logic [31:0]   pc, inst, upd_pc;
    logic [PW+CW-1:0] flush_ckpt;
    logic          branch_taken, is_branch, is_call, is_return;
    logic [31:0]   branch_address;
    logic [PW+CW-1:0] ras_ckpt;

    dynamic_branch_predictor #(
        .BHT_ENTRIES  (BHT),
        .RAS_DEPTH    (D),
        .COUNTER_INIT (2'b01)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .fetch_valid    (fetch_valid),
        .stall          (stall),
        .pc             (pc),
        .inst           (inst),
        .branch_taken   (branch_taken),
        .is_branch      (is_branch),
        .is_call        (is_call),
        .is_return      (is_return),
        .branch_address (branch_address),
        .ras_ckpt       (ras_ckpt),
        .upd_valid      (upd_valid),
        .upd_pc         (upd_pc),
        .upd_taken      (upd_taken),
        .flush          (flush),
        .flush_ckpt     (flush_ckpt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic             taken;
        logic             br;
        logic             call;
        logic             ret;
        logic [31:0]      tgt;
        logic [PW+CW-1:0] ckpt;
    } exp_t;

    exp_t             exp_q[$];
    logic [PW+CW-1:0] ck_hist[$];
    int               errors = 0;
    int               checks = 0;

    // Reference state: counters as integers 0..3, return stack as a ring of
    // addresses with a next-free index and an occupancy count.
    int          bht_m[BHT];
    logic [31:0] ras_m[D];
    int          sp, cnt;

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    function automatic exp_t predict(input logic [31:0] p, input logic [31:0] i, input bit fv);
        exp_t        e;
        logic [31:0] pc4, bt, jt, off;
        int          nsp, ncnt;
        bit          cond;
        e    = '0;
        nsp  = sp;
        ncnt = cnt;
        if (fv) begin
            pc4  = p + 32'd4;
            off  = {{16{i[15]}}, i[15:0]} << 2;
            bt   = pc4 + off;
            jt   = {pc4[31:28], i[25:0], 2'b00};
            cond = bht_m[(p >> 2) % BHT] >= 2;
            case (i[31:26])
                6'd2: begin e.br = 1; e.taken = 1; e.tgt = jt; end
                6'd3: begin e.br = 1; e.taken = 1; e.tgt = jt; e.call = 1; end
                6'd4, 6'd5, 6'd6, 6'd7: begin e.br = 1; e.taken = cond; e.tgt = bt; end
                6'd1: begin
                    if (i[20:16] == 5'd0 || i[20:16] == 5'd1) begin
                        e.br = 1; e.taken = cond; e.tgt = bt;
                    end else if (i[20:16] == 5'd16 || i[20:16] == 5'd17) begin
                        e.br = 1; e.taken = cond; e.tgt = bt; e.call = cond;
                    end
                end
                6'd0: begin
                    if (i[5:0] == 6'd8) begin
                        e.br = 1;
                        if (i[25:21] == 5'd31) begin
                            e.ret = 1;
                            if (cnt > 0) begin
                                e.taken = 1;
                                e.tgt   = ras_m[(sp + D - 1) % D];
                            end
                        end
                    end else if (i[5:0] == 6'd9) begin
                        e.br = 1; e.call = 1;
                    end
                end
                default: ;
            endcase
            if (e.call) begin
                nsp  = (sp + 1) % D;
                ncnt = (cnt < D) ? cnt + 1 : D;
            end else if (e.ret && cnt > 0) begin
                nsp  = (sp + D - 1) % D;
                ncnt = cnt - 1;
            end
        end
        e.ckpt = {nsp[PW-1:0], ncnt[CW-1:0]};
        return e;
    endfunction

    task automatic drive(input bit r, input bit fv, input bit st, input logic [31:0] p,
                         input logic [31:0] i, input bit uv, input bit ut,
                         input logic [31:0] up, input bit fl, input logic [PW+CW-1:0] fc);
        exp_t e;
        int   k;
        rst = r; fetch_valid = fv; stall = st; pc = p; inst = i;
        upd_valid = uv; upd_taken = ut; upd_pc = up; flush = fl; flush_ckpt = fc;
        e = predict(p, i, fv);
        if (fv && !r) begin
            exp_q.push_back(e);
            if (!st && !fl) ck_hist.push_back(e.ckpt);
        end
        if (r) begin
            foreach (bht_m[n]) bht_m[n] = 1;
            sp  = 0;
            cnt = 0;
        end else begin
            if (uv) begin
                k = (up >> 2) % BHT;
                if (ut) bht_m[k] = (bht_m[k] == 3) ? 3 : bht_m[k] + 1;
                else    bht_m[k] = (bht_m[k] == 0) ? 0 : bht_m[k] - 1;
            end
            if (fl) begin
                sp  = int'(fc[PW+CW-1:CW]);
                cnt = int'(fc[CW-1:0]);
            end else if (fv && !st) begin
                if (e.call) begin
                    ras_m[sp] = p + 32'd8;
                    sp  = (sp + 1) % D;
                    cnt = (cnt < D) ? cnt + 1 : D;
                end else if (e.ret && cnt > 0) begin
                    sp  = (sp + D - 1) % D;
                    cnt = cnt - 1;
                end
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fetch_i(input logic [31:0] p, input logic [31:0] i);
        drive(0, 1, 0, p, i, 0, 0, 32'd0, 0, '0);
    endtask

    task automatic upd(input logic [31:0] p, input bit t);
        drive(0, 0, 0, 32'd0, 32'd0, 1, t, p, 0, '0);
        tick();
    endtask

    function automatic logic [31:0] beq(input logic [15:0] imm);
        return {6'b000100, 5'd1, 5'd2, imm};
    endfunction
    function automatic logic [31:0] jal(input logic [25:0] t);
        return {6'b000011, t};
    endfunction
    function automatic logic [31:0] jr(input logic [4:0] rs);
        return {6'b000000, rs, 15'd0, 6'b001000};
    endfunction

    // Monitor: every presented fetch is compared against the queued expectation;
    // idle cycles must show all-false bools and a zero address.
    exp_t m_e;
    always @(negedge clk) begin
        if (fetch_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL scoreboard_empty: got output with no expectation pc=%0h", pc);
            end else begin
                m_e = exp_q.pop_front();
                chk("taken",     64'(branch_taken),   64'(m_e.taken));
                chk("is_branch", 64'(is_branch),      64'(m_e.br));
                chk("is_call",   64'(is_call),        64'(m_e.call));
                chk("is_return", 64'(is_return),      64'(m_e.ret));
                chk("target",    64'(branch_address), 64'(m_e.tgt));
                chk("ras_ckpt",  64'(ras_ckpt),       64'(m_e.ckpt));
            end
        end else if (fetch_valid === 1'b0) begin
            chk("idle_outputs", {28'd0, branch_taken, is_branch, is_call, is_return, branch_address}, 64'd0);
        end
    end

    initial begin
        logic [31:0] p, i, up;
        bit          fv, st, fl, uv, ut, r;
        logic [PW+CW-1:0] fc;

        // Reset and idle outputs
        drive(1, 0, 0, 32'd0, 32'd0, 0, 0, 32'd0, 0, '0);
        tick();
        tick();
        drive(0, 0, 0, 32'd0, 32'd0, 0, 0, 32'd0, 0, '0);
        #2;
        chk("reset_ckpt",   64'(ras_ckpt), 64'd0);
        chk("reset_target", 64'(branch_address), 64'd0);
        tick();

        // BHT: init weakly not-taken, train up, saturate down without underflow
        fetch_i(32'h8000_1000, beq(16'd4));
        #2;
        chk("beq_init_taken",  64'(branch_taken), 64'd0);
        chk("beq_init_target", 64'(branch_address), 64'h8000_1014);
        tick();
        upd(32'h8000_1000, 1);
        upd(32'h8000_1000, 1);
        fetch_i(32'h8000_1000, beq(16'd4));
        #2;
        chk("beq_trained_taken", 64'(branch_taken), 64'd1);
        tick();
        for (int n = 0; n < 4; n++) upd(32'h8000_1000, 0);
        fetch_i(32'h8000_1000, beq(16'd4));
        #2;
        chk("beq_floor_taken", 64'(branch_taken), 64'd0);
        tick();
        upd(32'h8000_1000, 1);
        fetch_i(32'h8000_1000, beq(16'd4));
        #2;
        chk("beq_no_underflow", 64'(branch_taken), 64'd0);
        tick();

        // JAL then JR $31
        fetch_i(32'h8000_0100, jal(26'h000_0400));
        #2;
        chk("jal_call",   64'(is_call), 64'd1);
        chk("jal_target", 64'(branch_address), 64'h8000_1000);
        tick();
        fetch_i(32'h8000_1000, jr(5'd31));
        #2;
        chk("jr_return", 64'(is_return), 64'd1);
        chk("jr_taken",  64'(branch_taken), 64'd1);
        chk("jr_target", 64'(branch_address), 64'h8000_0108);
        chk("jr_ckpt",   64'(ras_ckpt), 64'd0);
        tick();

        // Overflow: nine calls, nine returns; oldest entry lost
        for (int k = 0; k < 9; k++) begin
            fetch_i(32'h8000_0100 + 32'(k * 16), jal(26'd0));
            tick();
        end
        for (int k = 0; k < 9; k++) begin
            fetch_i(32'h8000_2000, jr(5'd31));
            #2;
            if (k < 8) begin
                chk("ovf_taken",  64'(branch_taken), 64'd1);
                chk("ovf_target", 64'(branch_address), 64'(32'h8000_0188 - 32'(k * 16)));
            end else begin
                chk("ovf_empty_taken", 64'(branch_taken), 64'd0);
            end
            tick();
        end

        // Stalled call holds state; released call pushes once (ptr now 1, count 0)
        drive(0, 1, 1, 32'h8000_0500, jal(26'd0), 0, 0, 32'd0, 0, '0);
        #2;
        chk("stall_ckpt", 64'(ras_ckpt), 64'({3'd2, 4'd1}));
        tick();
        fetch_i(32'h8000_0500, jal(26'd0));
        tick();
        fetch_i(32'h8000_3000, jr(5'd31));
        #2;
        chk("stall_ret_target", 64'(branch_address), 64'h8000_0508);
        tick();
        fetch_i(32'h8000_3000, jr(5'd31));
        #2;
        chk("stall_once", 64'(branch_taken), 64'd0);
        tick();

        // Flush restores checkpoint and drops the concurrent push
        fetch_i(32'h8000_0200, jal(26'd0));
        #2;
        chk("ckpt_jal1", 64'(ras_ckpt), 64'h21);
        tick();
        fetch_i(32'h8000_0300, jal(26'd0));
        tick();
        fetch_i(32'h8000_3000, jr(5'd31));
        tick();
        drive(0, 1, 0, 32'h8000_0400, jal(26'd0), 0, 0, 32'd0, 1, 7'h21);
        tick();
        fetch_i(32'h8000_3000, jr(5'd31));
        #2;
        chk("flush_ret_target", 64'(branch_address), 64'h8000_0208);
        tick();
        fetch_i(32'h8000_3000, jr(5'd31));
        #2;
        chk("flush_ret_empty", 64'(branch_taken), 64'd0);
        tick();

        // Same-cycle update is not bypassed
        drive(0, 1, 0, 32'h8000_1000, beq(16'd4), 1, 1, 32'h8000_1000, 0, '0);
        #2;
        chk("no_bypass_old", 64'(branch_taken), 64'd0);
        tick();
        fetch_i(32'h8000_1000, beq(16'd4));
        #2;
        chk("no_bypass_new", 64'(branch_taken), 64'd1);
        tick();
        fetch_i(32'h8000_1000, jr(5'd5));
        #2;
        chk("jr5_branch", 64'(is_branch), 64'd1);
        chk("jr5_taken",  64'(branch_taken), 64'd0);
        tick();

        // Reset with an in-flight update: counter returns to init
        drive(1, 0, 0, 32'd0, 32'd0, 1, 1, 32'h8000_1000, 0, '0);
        tick();
        fetch_i(32'h8000_1000, beq(16'd4));
        #2;
        chk("rst_drops_update", 64'(branch_taken), 64'd0);
        tick();
        ck_hist.delete();

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            r  = ($urandom_range(0, 499) == 0);
            fv = !r && ($urandom_range(0, 9) != 0);
            st = ($urandom_range(0, 7) == 0);
            fl = !r && ($urandom_range(0, 19) == 0) && (ck_hist.size() > 0);
            fc = '0;
            if (fl) fc = ck_hist[$urandom_range(0, ck_hist.size() - 1)];
            uv = ($urandom_range(0, 2) == 0);
            ut = $urandom_range(0, 1) == 1;
            up = 32'h8000_0100 + 32'($urandom_range(0, 7) * 4);
            if ($urandom_range(0, 7) == 0) up = up + 32'(BHT * 4);
            p  = 32'h8000_0100 + 32'($urandom_range(0, 7) * 4);
            if ($urandom_range(0, 7) == 0) p = p + 32'(BHT * 4);
            case ($urandom_range(0, 9))
                0: i = jal(26'($urandom));
                1, 2: i = jr(5'd31);
                3: i = beq(16'($urandom));
                4: i = {6'b000001, 5'd3, 5'($urandom_range(16, 17)), 16'($urandom)};
                5: i = {6'b000001, 5'd3, 5'($urandom_range(0, 3)), 16'($urandom)};
                6: i = {6'b000010, 26'($urandom)};
                7: i = jr(5'($urandom_range(0, 30)));
                8: i = {6'b000000, 5'd4, 5'd0, 5'd31, 5'd0, 6'b001001};
                default: i = $urandom;
            endcase
            drive(r, fv, st, p, i, uv, ut, up, fl, fc);
            if (r) ck_hist.delete();
            tick();
        end

        drive(0, 0, 0, 32'd0, 32'd0, 0, 0, 32'd0, 0, '0);
        tick();
        @(negedge clk);
        #1;
        chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
